// File: rtl/dbg_halt_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbg_pkg : shared types and defaults for the debug halt controller     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package dbg_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } dbg_state_e;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK = 2'd1;
  localparam logic [1:0] CAUSE_EXT    = 2'd2;
  localparam logic [1:0] CAUSE_STEP   = 2'd3;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_STEP_TIMEOUT = 64;

endpackage
`default_nettype wire

// File: rtl/dbg_halt_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbg_halt_ctrl_if : pipeline/debug signals of the halt controller      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface dbg_halt_ctrl_if;
  logic       ebreak_req;
  logic       halt_req;
  logic       resume;
  logic       step;
  logic       id_advance;
  logic       retire;
  logic       ebreak;
  logic       halted;
  logic [1:0] halt_cause;
  logic       timeout_flag;
  logic       step_done;

  modport master (
    output ebreak_req, halt_req, resume, step, id_advance, retire,
    input  ebreak, halted, halt_cause, timeout_flag, step_done
  );

  modport slave (
    input  ebreak_req, halt_req, resume, step, id_advance, retire,
    output ebreak, halted, halt_cause, timeout_flag, step_done
  );
endinterface
`default_nettype wire

// File: rtl/dbg_halt_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbg_sat_counter : up counter that sticks at all-ones, sync clear      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dbg_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/dbg_halt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dbg_halt_ctrl : debug halt/resume/single-step controller driving the  |
// | pipeline freeze. Optional DBG_HALT_CYCLES_EN adds halt_cycles output. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dbg_halt_ctrl
  import dbg_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int STEP_TIMEOUT = DEF_STEP_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  dbg_halt_ctrl_if.slave   dbg,
  output logic [CNT_W-1:0] halt_count
`ifdef DBG_HALT_CYCLES_EN
  ,
  output logic [31:0]      halt_cycles
`endif
);

  localparam int               TMR_W    = 16;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_TIMEOUT - 1);

  dbg_state_e       state_q, state_d;
  logic             skip_q, skip_d;
  logic [1:0]       cause_q, cause_d;
  logic             tflag_q, tflag_d;
  logic             step_done_q, step_done_d;
  logic             halted_q, halted_d;
  logic             enter_halt;
  logic             eb_hit;
  logic [TMR_W-1:0] timer;

  // The EBREAK that caused the halt is still sitting in ID; mask it until it moves on.
  assign eb_hit = dbg.ebreak_req && !skip_q;

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    cause_d     = cause_q;
    tflag_d     = tflag_q;
    step_done_d = 1'b0;
    enter_halt  = 1'b0;

    if ((state_q != HALTED) && skip_q && dbg.id_advance) begin
      skip_d = 1'b0;
    end

    case (state_q)
      RUN: begin
        if (eb_hit) begin
          enter_halt = 1'b1;
          cause_d    = CAUSE_EBREAK;
          tflag_d    = 1'b0;
        end else if (dbg.halt_req) begin
          enter_halt = 1'b1;
          cause_d    = CAUSE_EXT;
          tflag_d    = 1'b0;
        end
      end
      HALTED: begin
        if (dbg.resume) begin
          state_d = RUN;
          skip_d  = 1'b1;
        end else if (dbg.step) begin
          state_d = STEP;
          skip_d  = 1'b1;
        end
      end
      STEP: begin
        if (dbg.retire) begin
          enter_halt  = 1'b1;
          cause_d     = CAUSE_STEP;
          tflag_d     = 1'b0;
          step_done_d = 1'b1;
        end else if (eb_hit) begin
          enter_halt = 1'b1;
          cause_d    = CAUSE_EBREAK;
          tflag_d    = 1'b0;
        end else if (timer == TMR_LAST) begin
          enter_halt = 1'b1;
          cause_d    = CAUSE_STEP;
          tflag_d    = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (enter_halt) begin
      state_d = HALTED;
    end
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      skip_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      tflag_q     <= 1'b0;
      step_done_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      cause_q     <= cause_d;
      tflag_q     <= tflag_d;
      step_done_q <= step_done_d;
      halted_q    <= halted_d;
    end
  end

  dbg_sat_counter #(.W(CNT_W)) u_halt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (enter_halt),
    .clear (1'b0),
    .count (halt_count)
  );

  // Held at zero outside STEP, so every step starts from a fresh count.
  dbg_sat_counter #(.W(TMR_W)) u_step_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (state_q == STEP),
    .clear (state_q != STEP),
    .count (timer)
  );

`ifdef DBG_HALT_CYCLES_EN
  logic [31:0] halt_cycles_q, halt_cycles_d;

  always_comb begin
    halt_cycles_d = halt_cycles_q;
    if (halted_q) begin
      halt_cycles_d = halt_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_cycles_q <= 32'd0;
    end else begin
      halt_cycles_q <= halt_cycles_d;
    end
  end

  assign halt_cycles = halt_cycles_q;
`endif

  assign dbg.ebreak       = (state_q == HALTED) || eb_hit;
  assign dbg.halted       = halted_q;
  assign dbg.halt_cause   = cause_q;
  assign dbg.timeout_flag = tflag_q;
  assign dbg.step_done    = step_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dbg_halt_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dbg_halt_ctrl : directed table, corner sequences and random run    |
// | against a cycle model. Honours DBG_HALT_CYCLES_EN.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_dbg_halt_ctrl;

  localparam int CNT_W        = 4;
  localparam int STEP_TIMEOUT = 64;
  localparam int SAT_MAX      = (1 << CNT_W) - 1;

  typedef struct {
    logic er, hr, res, st, ida, ret;
  } in_t;

  typedef struct {
    in_t        i;
    logic       eb;
    logic       hl;
    logic [1:0] cause;
    logic       tf;
    logic       sd;
    logic [3:0] cnt;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] halt_count;
`ifdef DBG_HALT_CYCLES_EN
  logic [31:0]      halt_cycles;
`endif

  dbg_halt_ctrl_if u_if ();

  dbg_halt_ctrl #(.CNT_W(CNT_W), .STEP_TIMEOUT(STEP_TIMEOUT)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dbg        (u_if),
    .halt_count (halt_count)
`ifdef DBG_HALT_CYCLES_EN
    ,
    .halt_cycles(halt_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 0 running, 1 halted, 2 stepping
  int      m_mode, m_elapsed, m_entries, m_cause;
  bit      m_skip, m_tf, m_sd;
  longint  m_hcyc;
  logic    m_eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input logic er, hr, res, st, ida, ret);
    in_t v;
    v.er = er; v.hr = hr; v.res = res; v.st = st; v.ida = ida; v.ret = ret;
    return v;
  endfunction

  function automatic vec_t mkv(input in_t i, input logic eb, hl, input logic [1:0] c,
                               input logic tf, sd, input logic [3:0] cnt);
    vec_t v;
    v.i = i; v.eb = eb; v.hl = hl; v.cause = c; v.tf = tf; v.sd = sd; v.cnt = cnt;
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_entries = 0; m_cause = 0;
    m_skip = 0; m_tf = 0; m_sd = 0; m_hcyc = 0;
  endtask

  task automatic model_enter(input int c, input bit tf);
    m_mode = 1;
    m_entries++;
    m_cause = c;
    m_tf = tf;
  endtask

  task automatic model_update(input in_t v);
    bit was_skip;
    bit ebk;
    was_skip = m_skip;
    ebk      = v.er && !was_skip;
    m_sd     = 0;
    if (m_mode != 1 && was_skip && v.ida) m_skip = 0;
    if (m_mode == 0) begin
      if (ebk) model_enter(1, 0);
      else if (v.hr) model_enter(2, 0);
    end else if (m_mode == 1) begin
      m_hcyc = (m_hcyc + 1) % 64'h1_0000_0000;
      if (v.res) begin m_mode = 0; m_skip = 1; end
      else if (v.st) begin m_mode = 2; m_elapsed = 0; m_skip = 1; end
    end else begin
      m_elapsed++;
      if (v.ret) begin model_enter(3, 0); m_sd = 1; end
      else if (ebk) model_enter(1, 0);
      else if (m_elapsed == STEP_TIMEOUT) model_enter(3, 1);
    end
  endtask

  task automatic drive_phase(input in_t v);
    @(negedge clk);
    u_if.ebreak_req = v.er;
    u_if.halt_req   = v.hr;
    u_if.resume     = v.res;
    u_if.step       = v.st;
    u_if.id_advance = v.ida;
    u_if.retire     = v.ret;
    m_eb = (m_mode == 1) || (v.er && !m_skip);
    #1;
  endtask

  task automatic edge_phase(input in_t v);
    @(posedge clk);
    #1;
    model_update(v);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_halted"}, 32'(u_if.halted), 32'(m_mode == 1));
    chk({tag, "_cause"}, 32'(u_if.halt_cause), 32'(m_cause));
    chk({tag, "_timeout_flag"}, 32'(u_if.timeout_flag), 32'(m_tf));
    chk({tag, "_step_done"}, 32'(u_if.step_done), 32'(m_sd));
    chk({tag, "_halt_count"}, 32'(halt_count),
        32'((m_entries > SAT_MAX) ? SAT_MAX : m_entries));
`ifdef DBG_HALT_CYCLES_EN
    chk({tag, "_halt_cycles"}, halt_cycles, m_hcyc[31:0]);
`endif
  endtask

  task automatic tick(input in_t v, input string tag);
    drive_phase(v);
    chk({tag, "_ebreak"}, 32'(u_if.ebreak), 32'(m_eb));
    edge_phase(v);
    check_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    u_if.ebreak_req = 0; u_if.halt_req = 0; u_if.resume = 0;
    u_if.step = 0; u_if.id_advance = 0; u_if.retire = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ebreak", 32'(u_if.ebreak), 32'd0);
    chk("rst_halted", 32'(u_if.halted), 32'd0);
    chk("rst_cause", 32'(u_if.halt_cause), 32'd0);
    chk("rst_halt_count", 32'(halt_count), 32'd0);
    chk("rst_timeout_flag", 32'(u_if.timeout_flag), 32'd0);
    chk("rst_step_done", 32'(u_if.step_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[16];
  in_t  idle;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle  = mk(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    model_reset();

    // er  hr  res st  ida ret  | eb hl cause tf sd cnt
    tbl[0]  = mkv(mk(1,0,0,0,0,0), 1, 1, 2'd1, 0, 0, 4'd1);
    tbl[1]  = mkv(mk(1,0,0,0,0,0), 1, 1, 2'd1, 0, 0, 4'd1);
    tbl[2]  = mkv(mk(1,0,1,0,0,0), 1, 0, 2'd1, 0, 0, 4'd1);
    tbl[3]  = mkv(mk(1,0,0,0,0,0), 0, 0, 2'd1, 0, 0, 4'd1);
    tbl[4]  = mkv(mk(1,0,0,0,1,0), 0, 0, 2'd1, 0, 0, 4'd1);
    tbl[5]  = mkv(mk(0,0,0,0,1,0), 0, 0, 2'd1, 0, 0, 4'd1);
    tbl[6]  = mkv(mk(1,1,0,0,0,0), 1, 1, 2'd1, 0, 0, 4'd2);
    tbl[7]  = mkv(mk(0,0,1,1,0,0), 1, 0, 2'd1, 0, 0, 4'd2);
    tbl[8]  = mkv(mk(0,1,0,0,0,0), 0, 1, 2'd2, 0, 0, 4'd3);
    tbl[9]  = mkv(mk(0,0,0,1,0,0), 1, 0, 2'd2, 0, 0, 4'd3);
    tbl[10] = mkv(mk(0,0,0,0,1,0), 0, 0, 2'd2, 0, 0, 4'd3);
    tbl[11] = mkv(mk(0,1,0,0,0,0), 0, 0, 2'd2, 0, 0, 4'd3);
    tbl[12] = mkv(mk(0,0,0,0,0,0), 0, 0, 2'd2, 0, 0, 4'd3);
    tbl[13] = mkv(mk(0,0,0,0,0,0), 0, 0, 2'd2, 0, 0, 4'd3);
    tbl[14] = mkv(mk(0,0,0,0,0,1), 0, 1, 2'd3, 0, 1, 4'd4);
    tbl[15] = mkv(mk(0,0,0,0,0,0), 1, 1, 2'd3, 0, 0, 4'd4);

    do_reset();

    for (int k = 0; k < 16; k++) begin
      drive_phase(tbl[k].i);
      chk($sformatf("tbl%0d_ebreak", k), 32'(u_if.ebreak), 32'(tbl[k].eb));
      edge_phase(tbl[k].i);
      chk($sformatf("tbl%0d_halted", k), 32'(u_if.halted), 32'(tbl[k].hl));
      chk($sformatf("tbl%0d_cause", k), 32'(u_if.halt_cause), 32'(tbl[k].cause));
      chk($sformatf("tbl%0d_tflag", k), 32'(u_if.timeout_flag), 32'(tbl[k].tf));
      chk($sformatf("tbl%0d_step_done", k), 32'(u_if.step_done), 32'(tbl[k].sd));
      chk($sformatf("tbl%0d_count", k), 32'(halt_count), 32'(tbl[k].cnt));
    end

    // Step with no retirement: forced re-halt after exactly STEP_TIMEOUT cycles
    tick(mk(0,0,0,1,0,0), "to_step");
    for (int k = 1; k <= STEP_TIMEOUT; k++) begin
      tick(idle, "to_run");
      if (k == STEP_TIMEOUT - 1) chk("to_not_yet_halted", 32'(u_if.halted), 32'd0);
      if (k == STEP_TIMEOUT) begin
        chk("to_halted", 32'(u_if.halted), 32'd1);
        chk("to_cause", 32'(u_if.halt_cause), 32'd3);
        chk("to_flag", 32'(u_if.timeout_flag), 32'd1);
        chk("to_count", 32'(halt_count), 32'd5);
      end
    end
    tick(mk(0,0,1,0,0,0), "to_resume");

    // Reset in the middle of a step
    tick(mk(0,1,0,0,0,0), "ms_halt");
    tick(mk(0,0,0,1,0,0), "ms_step");
    for (int k = 0; k < 10; k++) tick(idle, "ms_run");
    do_reset();

    // Three halts of seven cycles each, then saturation of halt_count
    for (int h = 0; h < 3; h++) begin
      tick(mk(0,1,0,0,0,0), "hc_halt");
      for (int k = 0; k < 6; k++) tick(idle, "hc_wait");
      tick(mk(0,0,1,0,0,0), "hc_resume");
    end
`ifdef DBG_HALT_CYCLES_EN
    chk("hc_total", halt_cycles, 32'd21);
`endif
    chk("hc_count", 32'(halt_count), 32'd3);
    for (int h = 0; h < 17; h++) begin
      tick(mk(0,1,0,0,0,0), "sat_halt");
      tick(mk(0,0,1,0,0,0), "sat_resume");
    end
    chk("sat_count", 32'(halt_count), 32'd15);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      in_t v;
      v.er  = ($urandom_range(0, 3) == 0);
      v.hr  = ($urandom_range(0, 9) == 0);
      v.res = ($urandom_range(0, 9) == 0);
      v.st  = ($urandom_range(0, 7) == 0);
      v.ida = ($urandom_range(0, 1) == 0);
      v.ret = ($urandom_range(0, 19) == 0);
      tick(v, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
